// File: rtl/core_lsu.sv
// rtl/core_lsu.sv - MEM-stage load/store unit with req/gnt/rvalid data bus
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning them down.
module core_lsu #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   input  logic            i_mem_read,
   input  logic            i_mem_write,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [4:0]      i_rd,
   output logic            o_stall,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [3:0]      o_dmem_be,
   output logic [XLEN-1:0] o_dmem_wdata,
   input  logic            i_dmem_gnt,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_wb_valid,
   output logic [4:0]      o_wb_rd,
   output logic [XLEN-1:0] o_wb_data,
   output logic            o_misaligned
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      state;
   logic            load_q;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;
   logic [4:0]      rd_q;

   logic            is_mem;
   logic            mis_acc;
   logic [3:0]      st_be;
   logic [XLEN-1:0] st_wdata;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;

   assign is_mem  = i_valid & (i_mem_read | i_mem_write);
   assign o_stall = ((state == S_IDLE) & is_mem) | (state == S_REQ) | (state == S_RESP);

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis_acc = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                    ((i_funct3 == 3'b010) & (i_addr[1:0] != 2'b00));
`else
   assign mis_acc = 1'b0;
`endif

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = i_wdata;
      case (i_funct3)
         3'b000: begin
            st_be    = 4'b0001 << i_addr[1:0];
            st_wdata = {4{i_wdata[7:0]}};
         end
         3'b001: begin
            st_be    = 4'b0011 << {i_addr[1], 1'b0};
            st_wdata = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection ignores any misalignment the trap logic did not catch.
   always_comb begin
      ld_byte = i_dmem_rdata[7:0];
      case (off_q)
         2'd1:    ld_byte = i_dmem_rdata[15:8];
         2'd2:    ld_byte = i_dmem_rdata[23:16];
         2'd3:    ld_byte = i_dmem_rdata[31:24];
         default: ;
      endcase
      ld_half = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = i_dmem_rdata;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         load_q       <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         rd_q         <= 5'd0;
         o_dmem_req   <= 1'b0;
         o_dmem_we    <= 1'b0;
         o_dmem_addr  <= '0;
         o_dmem_be    <= 4'd0;
         o_dmem_wdata <= '0;
         o_wb_valid   <= 1'b0;
         o_wb_rd      <= 5'd0;
         o_wb_data    <= '0;
         o_misaligned <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_mem) begin
                  load_q   <= i_mem_read;
                  funct3_q <= i_funct3;
                  off_q    <= i_addr[1:0];
                  rd_q     <= i_rd;
                  if (mis_acc) begin
                     o_misaligned <= 1'b1;
                     state        <= S_DONE;
                  end else begin
                     o_dmem_req  <= 1'b1;
                     o_dmem_we   <= ~i_mem_read;
                     o_dmem_addr <= {i_addr[XLEN-1:2], 2'b00};
                     if (i_mem_read) begin
                        o_dmem_be    <= 4'b1111;
                        o_dmem_wdata <= '0;
                     end else begin
                        o_dmem_be    <= st_be;
                        o_dmem_wdata <= st_wdata;
                     end
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (i_dmem_gnt) begin
                  o_dmem_req <= 1'b0;
                  state      <= load_q ? S_RESP : S_DONE;
               end
            end
            S_RESP: begin
               if (i_dmem_rvalid) begin
                  o_wb_valid <= 1'b1;
                  o_wb_rd    <= rd_q;
                  o_wb_data  <= ld_data;
                  state      <= S_DONE;
               end
            end
            default: begin
               o_wb_valid   <= 1'b0;
               o_misaligned <= 1'b0;
               state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_lsu.sv
// tb/tb_core_lsu.sv - scoreboard bench for core_lsu
module tb_core_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_mem_read = 1'b0;
   logic        i_mem_write = 1'b0;
   logic [2:0]  i_funct3 = 3'd0;
   logic [31:0] i_addr = 32'd0;
   logic [31:0] i_wdata = 32'd0;
   logic [4:0]  i_rd = 5'd0;
   logic        o_stall;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_dmem_wdata;
   logic        i_dmem_gnt = 1'b0;
   logic        i_dmem_rvalid = 1'b0;
   logic [31:0] i_dmem_rdata = 32'd0;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   logic        o_misaligned;

   core_lsu #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_funct3(i_funct3),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd), .o_stall(o_stall),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_gnt(i_dmem_gnt),
      .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
      .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
      .o_misaligned(o_misaligned)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      int          reqcyc;
   } bus_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   bus_t bus_q[$];
   wb_t  wb_q[$];
   int   stall_q[$];
   int   mis_q[$];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_unexp(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got unexpected event expected none", name);
   endtask

   // Monitor: compares every bus request, writeback, trap flag and stall run against the queues.
   bus_t cur_bus;
   bit   in_req = 0;
   int   req_run = 0;
   int   stall_run = 0;

   always @(negedge i_clk) begin
      if (o_dmem_req) begin
         if (!in_req) begin
            if (bus_q.size() == 0) fail_unexp("bus_req");
            else cur_bus = bus_q.pop_front();
            in_req = 1;
            req_run = 0;
         end
         req_run++;
         chk("bus_addr", o_dmem_addr, cur_bus.addr);
         chk("bus_be", {28'd0, o_dmem_be}, {28'd0, cur_bus.be});
         chk("bus_we", {31'd0, o_dmem_we}, {31'd0, cur_bus.we});
         if (cur_bus.we) chk("bus_wdata", o_dmem_wdata, cur_bus.wdata);
      end else if (in_req) begin
         chk("req_cycles", req_run, cur_bus.reqcyc);
         in_req = 0;
      end

      if (o_wb_valid) begin
         if (wb_q.size() == 0) fail_unexp("wb_valid");
         else begin
            wb_t w;
            w = wb_q.pop_front();
            chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, w.rd});
            chk("wb_data", o_wb_data, w.data);
         end
      end

      if (o_misaligned) begin
         if (mis_q.size() == 0) fail_unexp("misaligned");
         else begin
            void'(mis_q.pop_front());
            chk("mis_wb_valid", {31'd0, o_wb_valid}, 32'd0);
         end
      end

      if (o_stall) stall_run++;
      else if (stall_run > 0) begin
         if (stall_q.size() == 0) fail_unexp("stall_run");
         else chk("stall_cycles", stall_run, stall_q.pop_front());
         stall_run = 0;
      end
   end

   task automatic access(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input int gd, input logic rv_junk, input logic [31:0] rdata,
                         input logic exp_mis, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
      bus_t b;
      wb_t  w;
      if (exp_mis) begin
         mis_q.push_back(1);
         stall_q.push_back(1);
      end else begin
         b.addr = {addr[31:2], 2'b00};
         b.be = exp_be;
         b.wdata = exp_wdata;
         b.we = !rd_op;
         b.reqcyc = gd + 1;
         bus_q.push_back(b);
         stall_q.push_back(rd_op ? 3 + gd : 2 + gd);
         if (rd_op) begin
            w.rd = rd;
            w.data = exp_wb;
            wb_q.push_back(w);
         end
      end
      @(posedge i_clk); #1;
      i_valid = 1; i_mem_read = rd_op; i_mem_write = wr_op;
      i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_rd = rd;
      if (!exp_mis) begin
         @(posedge i_clk); #1;
         i_dmem_gnt = (gd == 0);
         i_dmem_rvalid = rv_junk;
         i_dmem_rdata = 32'h5A5A_5A5A;
         for (int k = 0; k < gd; k++) begin
            @(posedge i_clk); #1;
            if (k == gd - 1) i_dmem_gnt = 1;
         end
         @(posedge i_clk); #1;
         i_dmem_gnt = 0;
         i_dmem_rvalid = 0;
         if (rd_op) begin
            i_dmem_rvalid = 1;
            i_dmem_rdata = rdata;
            @(posedge i_clk); #1;
            i_dmem_rvalid = 0;
         end
      end else begin
         @(posedge i_clk); #1;
      end
      i_valid = 0; i_mem_read = 0; i_mem_write = 0;
      @(posedge i_clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("rst_mis", {31'd0, o_misaligned}, 32'd0);
      chk("rst_addr", o_dmem_addr, 32'd0);
      chk("rst_wb_data", o_wb_data, 32'd0);
      @(posedge i_clk); #1;
      i_rst = 0;

      //     rd wr f3      addr          wdata         rd gd junk rdata        mis be       exp_wdata     exp_wb
      access(1, 0, 3'b010, 32'h0000_0100, 32'h0,        5,  0, 0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
      access(1, 0, 3'b000, 32'h0000_0103, 32'h0,        6,  0, 0, 32'h80FF_FF00, 0, 4'b1111, 32'h0,        32'hFFFF_FF80);
      access(1, 0, 3'b100, 32'h0000_0103, 32'h0,        7,  0, 0, 32'h80FF_FF00, 0, 4'b1111, 32'h0,        32'h0000_0080);
      access(1, 0, 3'b101, 32'h0000_0102, 32'h0,        8,  0, 0, 32'h8001_0000, 0, 4'b1111, 32'h0,        32'h0000_8001);
      access(1, 0, 3'b001, 32'h0000_0102, 32'h0,        9,  0, 0, 32'h8001_0000, 0, 4'b1111, 32'h0,        32'hFFFF_8001);
      access(1, 0, 3'b000, 32'h0000_0101, 32'h0,        11, 0, 0, 32'h0000_7F00, 0, 4'b1111, 32'h0,        32'h0000_007F);
      access(0, 1, 3'b000, 32'h0000_0202, 32'h1234_5678, 0, 0, 0, 32'h0,        0, 4'b0100, 32'h7878_7878, 32'h0);
      access(0, 1, 3'b001, 32'h0000_0202, 32'h1234_5678, 0, 0, 0, 32'h0,        0, 4'b1100, 32'h5678_5678, 32'h0);
      access(0, 1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 0, 4, 0, 32'h0,        0, 4'b1111, 32'hCAFE_F00D, 32'h0);
      access(1, 0, 3'b010, 32'h0000_0300, 32'h0,        0,  4, 1, 32'h1122_3344, 0, 4'b1111, 32'h0,        32'h1122_3344);
      access(1, 1, 3'b010, 32'h0000_0400, 32'hFFFF_FFFF, 10, 0, 0, 32'hA5A5_0F0F, 0, 4'b1111, 32'h0,        32'hA5A5_0F0F);
`ifdef LSU_MISALIGN_TRAP_EN
      access(1, 0, 3'b010, 32'h0000_0101, 32'h0,        12, 0, 0, 32'h0,        1, 4'b1111, 32'h0,        32'h0);
`else
      access(1, 0, 3'b010, 32'h0000_0101, 32'h0,        12, 0, 0, 32'h0BAD_F00D, 0, 4'b1111, 32'h0,        32'h0BAD_F00D);
`endif

      // Non-memory instruction: no stall, no bus activity.
      i_valid = 1; i_mem_read = 0; i_mem_write = 0;
      @(negedge i_clk);
      chk("nonmem_stall", {31'd0, o_stall}, 32'd0);
      @(posedge i_clk); #1;
      i_valid = 0;
      @(negedge i_clk);
      chk("nonmem_req", {31'd0, o_dmem_req}, 32'd0);

      // Reset while waiting for read data.
      begin
         bus_t b;
         b.addr = 32'h0000_0500; b.be = 4'b1111; b.wdata = 32'h0; b.we = 0; b.reqcyc = 1;
         bus_q.push_back(b);
         stall_q.push_back(3);
      end
      @(posedge i_clk); #1;
      i_valid = 1; i_mem_read = 1; i_funct3 = 3'b010; i_addr = 32'h0000_0500; i_rd = 13;
      @(posedge i_clk); #1;
      i_dmem_gnt = 1;
      @(posedge i_clk); #1;
      i_dmem_gnt = 0;
      i_rst = 1; i_valid = 0; i_mem_read = 0;
      @(negedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      chk("midrst_req", {31'd0, o_dmem_req}, 32'd0);
      chk("midrst_stall", {31'd0, o_stall}, 32'd0);
      chk("midrst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      @(posedge i_clk); #1;
      i_rst = 0;
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);

      chk("bus_q_empty", bus_q.size(), 0);
      chk("wb_q_empty", wb_q.size(), 0);
      chk("stall_q_empty", stall_q.size(), 0);
      chk("mis_q_empty", mis_q.size(), 0);
      chk("final_stall", {31'd0, o_stall}, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
